// File: rtl/cache_line_engine.sv
// Cache line buffer plus block-transfer requester: fills the 32-word buffer from BRAM
// or writes it back as one block operation, with word access to the buffer while idle.
module cache_line_engine #(
   parameter int DATA_WIDTH         = 32,
   parameter int ADDR_WIDTH         = 16,
   parameter int BLOCK_OFFSET_WIDTH = 5,
   parameter int TIMEOUT            = 63
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_fill,
   input  logic                          req_wb,
   input  logic [ADDR_WIDTH-1:0]         req_addr,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   input  logic [BLOCK_OFFSET_WIDTH-1:0] buf_addr,
   input  logic                          buf_we,
   input  logic [DATA_WIDTH-1:0]         buf_wdata,
   output logic [DATA_WIDTH-1:0]         buf_rdata,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic                          mem_enable,
   output logic                          mem_rw,
   output logic                          mem_op_size,
   output logic                          mem_finishes_op,
   output logic [DATA_WIDTH-1:0]         mem_data_write,
   input  logic                          mem_data_write_req,
   input  logic [DATA_WIDTH-1:0]         mem_data_read,
   input  logic                          mem_data_read_valid,
   input  logic                          mem_finished
);
   localparam int BLOCK_SIZE = 1 << BLOCK_OFFSET_WIDTH;
   localparam int TW         = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
   localparam logic [BLOCK_OFFSET_WIDTH:0] RFULL = (BLOCK_OFFSET_WIDTH + 1)'(BLOCK_SIZE);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WB, S_DONE} state_t;

   state_t state, state_nxt;
   logic [DATA_WIDTH-1:0]         buffer [BLOCK_SIZE];
   logic [BLOCK_OFFSET_WIDTH:0]   rcnt;
   logic [BLOCK_OFFSET_WIDTH-1:0] wptr;
   logic [TW-1:0]                 tcnt;
   logic start_fill, start_wb, timed_out, fill_wr, xfer;
   logic unused_offset;

   assign unused_offset   = ^req_addr[BLOCK_OFFSET_WIDTH-1:0];
   assign busy            = (state != S_IDLE);
   assign done            = (state == S_DONE);
   assign mem_op_size     = 1'b0;
   assign mem_finishes_op = 1'b0;
   assign mem_data_write  = buffer[wptr];
   assign xfer            = (state == S_FILL) || (state == S_WB);
   // Words beyond the block are dropped: the controller may hold valid after the last one.
   assign fill_wr         = (state == S_FILL) && mem_data_read_valid && (rcnt < RFULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      start_fill = 1'b0;
      start_wb   = 1'b0;
      timed_out  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_wb) begin
               start_wb  = 1'b1;
               state_nxt = S_WB;
            end else if (req_fill) begin
               start_fill = 1'b1;
               state_nxt  = S_FILL;
            end
         end
         S_FILL, S_WB: begin
            // Completion beats a coincident timeout.
            if (mem_finished) begin
               state_nxt = S_DONE;
            end else if (tcnt == TLAST) begin
               timed_out = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_enable <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         err        <= 1'b0;
         rcnt       <= '0;
         wptr       <= '0;
         tcnt       <= '0;
      end else begin
         mem_enable <= start_fill | start_wb;
         if (start_fill | start_wb) begin
            mem_addr <= {req_addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH], BLOCK_OFFSET_WIDTH'(0)};
            mem_rw   <= start_wb;
            err      <= 1'b0;
            rcnt     <= '0;
            wptr     <= '0;
            tcnt     <= '0;
         end else if (xfer) begin
            tcnt <= tcnt + 1'b1;
            if (timed_out) err <= 1'b1;
            if (fill_wr) rcnt <= rcnt + 1'b1;
            // Word 0 goes out at the issue edge, then one word per write request.
            if ((state == S_WB) && (mem_enable || mem_data_write_req) && (wptr != '1))
               wptr <= wptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BLOCK_SIZE; i++) buffer[i] <= '0;
         buf_rdata <= '0;
      end else begin
         if (!busy && buf_we)
            buffer[buf_addr] <= buf_wdata;
         else if (fill_wr)
            buffer[rcnt[BLOCK_OFFSET_WIDTH-1:0]] <= mem_data_read;
         buf_rdata <= buffer[buf_addr];
      end
   end
endmodule
